// File: rtl/wall_slice_render.sv
// Wall slice renderer: per-column setup (texture step by division, start offset by
// multiplication) followed by a per-pixel texture-v accumulator along the trace line.
module wall_slice_render #(
  parameter int H_VIEW   = 640,
  parameter int SIZE_W   = 11,
  parameter int TEX_BITS = 6,
  parameter int FRAC     = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                side,
  input  logic [SIZE_W-1:0]   size,
  input  logic [TEX_BITS-1:0] texu,
  input  logic [9:0]          hpos,
  output logic                busy,
  output logic                ready,
  output logic                hit,
  output logic [TEX_BITS-1:0] texv,
  output logic [5:0]          rgb
);

  localparam int HALF    = H_VIEW / 2;
  localparam int TEX     = 1 << TEX_BITS;
  localparam int SW      = TEX_BITS + FRAC + 1;
  localparam int LW      = SIZE_W + 1;
  localparam int ACC_W   = SIZE_W + SW;
  localparam int CNT_MAX = (SW > SIZE_W) ? SW : SIZE_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [SW-1:0] DIVIDEND = SW'(TEX) << FRAC;
  localparam logic [31:0]   HALF_U   = 32'(HALF);
  localparam logic [31:0]   LAST_U   = 32'(H_VIEW - 1);

  typedef enum logic [1:0] {IDLE, DIV, MUL, READY} state_t;

  state_t              state_q, state_d;
  logic                start_q, start_d;
  logic                side_q, side_d;
  logic [TEX_BITS-1:0] texu_q, texu_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [LW-1:0]       l_q, l_d;
  logic [LW-1:0]       rem_q, rem_d;
  logic [SW-1:0]       div_q, div_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]       step_q, step_d;
  logic [SIZE_W-1:0]   mplier_q, mplier_d;
  logic [ACC_W-1:0]    mcand_q, mcand_d;
  logic [ACC_W-1:0]    acc0_q, acc0_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                hit_q, hit_d;
  logic [TEX_BITS-1:0] texv_q, texv_d;
  logic [5:0]          rgb_q, rgb_d;

  logic [31:0]         size_ext, hpos_ext, start_pos, end_pos;
  logic                in_span;
  logic [SIZE_W-1:0]   skip;
  logic [LW:0]         rem_shift;
  logic                rem_ge;
  logic [SW-1:0]       div_next;
  logic [ACC_W-1:0]    acc_base;
  logic [ACC_W:0]      acc_sum;
  logic [5:0]          colour;

  function automatic logic [TEX_BITS-1:0] sat_tex(input logic [ACC_W-FRAC-1:0] whole);
    if (whole > (ACC_W-FRAC)'(TEX - 1)) return '1;
    return whole[TEX_BITS-1:0];
  endfunction

  // Span geometry: the wall is mirrored about HALF and clipped to the visible line.
  assign size_ext  = 32'(size_q);
  assign hpos_ext  = 32'(hpos);
  assign start_pos = (size_ext > HALF_U) ? 32'd0 : HALF_U - size_ext;
  assign end_pos   = (HALF_U + size_ext > LAST_U) ? LAST_U : HALF_U + size_ext;
  assign in_span   = (hpos_ext >= start_pos) && (hpos_ext <= end_pos);
  assign skip      = (size_ext > HALF_U) ? SIZE_W'(size_ext - HALF_U) : '0;

  // One restoring-division step: dividend bits shift out of div_q as quotient bits shift in.
  assign rem_shift = {rem_q, div_q[SW-1]};
  assign rem_ge    = rem_shift >= {1'b0, l_q};
  assign div_next  = {div_q[SW-2:0], rem_ge};

  assign acc_base = (hpos_ext == start_pos) ? acc0_q : acc_q;
  assign acc_sum  = {1'b0, acc_base} + (ACC_W+1)'(step_q);

  assign colour = (texu_q == '0)                    ? 6'b111000 :
                  (texu_q == TEX_BITS'(TEX - 1))    ? 6'b010000 :
                  side_q                            ? 6'b110000 : 6'b100000;

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    side_d   = side_q;
    texu_d   = texu_q;
    size_d   = size_q;
    l_d      = l_q;
    rem_d    = rem_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    acc0_d   = acc0_q;
    acc_d    = acc_q;
    hit_d    = 1'b0;
    texv_d   = '0;
    rgb_d    = '0;

    if (state_q == READY && in_span) begin
      hit_d  = 1'b1;
      texv_d = sat_tex(acc_base[ACC_W-1:FRAC]);
      rgb_d  = colour;
      acc_d  = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    end

    // A load always wins over the sequencer, so a busy setup is simply restarted.
    if (load) begin
      state_d = IDLE;
      start_d = 1'b1;
      side_d  = side;
      texu_d  = texu;
      size_d  = size;
      l_d     = {size, 1'b1};
    end else begin
      case (state_q)
        IDLE: begin
          if (start_q) begin
            state_d = DIV;
            start_d = 1'b0;
            rem_d   = '0;
            div_d   = DIVIDEND;
            cnt_d   = '0;
          end
        end
        DIV: begin
          rem_d = rem_ge ? LW'(rem_shift - {1'b0, l_q}) : LW'(rem_shift);
          div_d = div_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(SW - 1)) begin
            state_d  = MUL;
            step_d   = div_next;
            mcand_d  = ACC_W'(div_next);
            mplier_d = skip;
            acc0_d   = '0;
            cnt_d    = '0;
          end
        end
        MUL: begin
          acc0_d   = acc0_q + (mplier_q[0] ? mcand_q : '0);
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(SIZE_W - 1)) begin
            state_d = READY;
            acc_d   = acc0_d;
          end
        end
        READY: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      side_q   <= 1'b0;
      texu_q   <= '0;
      size_q   <= '0;
      l_q      <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      step_q   <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      acc0_q   <= '0;
      acc_q    <= '0;
      hit_q    <= 1'b0;
      texv_q   <= '0;
      rgb_q    <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      side_q   <= side_d;
      texu_q   <= texu_d;
      size_q   <= size_d;
      l_q      <= l_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      acc0_q   <= acc0_d;
      acc_q    <= acc_d;
      hit_q    <= hit_d;
      texv_q   <= texv_d;
      rgb_q    <= rgb_d;
    end
  end

  assign busy  = (state_q == DIV) || (state_q == MUL);
  assign ready = (state_q == READY);
  assign hit   = hit_q;
  assign texv  = texv_q;
  assign rgb   = rgb_q;

endmodule

// File: tb/tb_wall_slice_render.sv
// Scoreboard bench for wall_slice_render: stimulus pushes reference pixels into a queue,
// a monitor pops one per clock and compares against the registered outputs.
module tb_wall_slice_render;

  localparam int H_VIEW = 640;
  localparam int HALF   = 320;
  localparam int TEX    = 64;
  localparam int FRAC   = 10;

  logic        clk = 1'b0;
  logic        reset, load, side;
  logic [10:0] size;
  logic [5:0]  texu;
  logic [9:0]  hpos;
  logic        busy, ready, hit;
  logic [5:0]  texv, rgb;

  wall_slice_render dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .side  (side),
    .size  (size),
    .texu  (texu),
    .hpos  (hpos),
    .busy  (busy),
    .ready (ready),
    .hit   (hit),
    .texv  (texv),
    .rgb   (rgb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       chk_t;
    logic       rdy;
    logic       hit;
    logic [5:0] texv;
    logic [5:0] rgb;
    logic [9:0] h;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  int     n_vec = 0;
  int     n_bad = 0;
  int     seen_texv[H_VIEW];

  longint m_step, m_acc0, m_acc;
  int     m_start, m_end;
  logic [5:0] m_rgb;

  // Reference geometry straight from the slice definition, in plain integer arithmetic.
  task automatic setup_model(input int sz, input int tu, input bit sd);
    int l;
    int skip;
    l      = 2 * sz + 1;
    m_step = longint'(TEX * (1 << FRAC)) / l;
    skip   = (sz > HALF) ? sz - HALF : 0;
    m_start = (skip > 0) ? 0 : HALF - sz;
    m_end   = (HALF + sz > H_VIEW - 1) ? H_VIEW - 1 : HALF + sz;
    m_acc0 = longint'(skip) * m_step;
    m_acc  = m_acc0;
    if (tu == 0)            m_rgb = 6'b111000;
    else if (tu == TEX - 1) m_rgb = 6'b010000;
    else if (sd)            m_rgb = 6'b110000;
    else                    m_rgb = 6'b100000;
  endtask

  function automatic exp_t model_pixel(input int h);
    exp_t   e;
    longint base;
    e       = '0;
    e.h     = 10'(h);
    e.rdy   = 1'b1;
    e.chk_t = 1'b1;
    if (h >= m_start && h <= m_end) begin
      base   = (h == m_start) ? m_acc0 : m_acc;
      e.hit  = 1'b1;
      e.texv = (base / 1024 > 63) ? 6'd63 : 6'(base / 1024);
      e.rgb  = m_rgb;
      m_acc  = base + m_step;
    end
    return e;
  endfunction

  function automatic exp_t idle_pixel(input int h);
    exp_t e;
    e   = '0;
    e.h = 10'(h);
    return e;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Monitor: one registered result per clock for every queued pixel.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        n_vec++;
        if (int'(mon_e.h) < H_VIEW) seen_texv[mon_e.h] = int'(texv);
        if (hit !== mon_e.hit || rgb !== mon_e.rgb || ready !== mon_e.rdy ||
            (mon_e.chk_t && texv !== mon_e.texv)) begin
          n_bad++;
          $display("[TB] FAIL pixel hpos=%0d: got hit=%b ready=%b texv=%0d rgb=%b, want hit=%b ready=%b texv=%0d rgb=%b",
                   mon_e.h, hit, ready, texv, rgb, mon_e.hit, mon_e.rdy, mon_e.texv, mon_e.rgb);
        end
      end
    end
  end

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 8) begin
      @(posedge clk);
      #2;
      t++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("[TB] FAIL drain: got %0d pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic applyStimulus(input int lo, input int hi, input bit rdy);
    for (int h = lo; h <= hi; h++) begin
      @(negedge clk);
      hpos = 10'(h);
      if (rdy) sb.push_back(model_pixel(h));
      else     sb.push_back(idle_pixel(h));
    end
    drain();
  endtask

  task automatic pulse_load(input int sz, input int tu, input bit sd);
    @(negedge clk);
    load = 1'b1;
    size = 11'(sz);
    texu = 6'(tu);
    side = sd;
    @(posedge clk);
    #1;
    load = 1'b0;
    setup_model(sz, tu, sd);
  endtask

  // Counts from the load edge: ready must rise 29 edges later after 28 busy cycles.
  task automatic wait_ready();
    int n;
    int busy_cnt;
    n = 0;
    busy_cnt = 0;
    while (ready !== 1'b1 && n < 60) begin
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("ready_latency", n, 29);
    checkOutput("busy_cycles", busy_cnt, 28);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sz, tu, lo, hi;
    bit sd;
    reset = 1'b1;
    load  = 1'b0;
    side  = 1'b0;
    size  = '0;
    texu  = '0;
    hpos  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy",  int'(busy),  0);
    checkOutput("reset_ready", int'(ready), 0);
    checkOutput("reset_hit",   int'(hit),   0);
    checkOutput("reset_texv",  int'(texv),  0);
    checkOutput("reset_rgb",   int'(rgb),   0);
    @(negedge clk);
    reset = 1'b0;

    pulse_load(0, 5, 1'b0);
    wait_ready();
    applyStimulus(318, 322, 1'b1);

    pulse_load(31, 7, 1'b0);
    wait_ready();
    applyStimulus(288, 352, 1'b1);
    checkOutput("s31_texv_first", seen_texv[289], 0);
    checkOutput("s31_texv_last",  seen_texv[351], 62);

    pulse_load(320, 9, 1'b1);
    wait_ready();
    applyStimulus(0, 639, 1'b1);
    checkOutput("s320_texv_0",   seen_texv[0],   0);
    checkOutput("s320_texv_639", seen_texv[639], 63);

    pulse_load(2047, 20, 1'b0);
    wait_ready();
    applyStimulus(0, 639, 1'b1);
    checkOutput("s2047_texv_0",   seen_texv[0],   26);
    checkOutput("s2047_texv_639", seen_texv[639], 36);
    applyStimulus(0, 639, 1'b1);
    checkOutput("s2047_rep_texv_0",   seen_texv[0],   26);
    checkOutput("s2047_rep_texv_639", seen_texv[639], 36);

    pulse_load(10, 3, 1'b0);
    repeat (7) @(posedge clk);
    pulse_load(31, 3, 1'b0);
    wait_ready();
    applyStimulus(280, 360, 1'b1);
    checkOutput("abort_texv_last", seen_texv[351], 62);

    pulse_load(100, 4, 1'b0);
    repeat (21) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("mulreset_busy",  int'(busy),  0);
    checkOutput("mulreset_ready", int'(ready), 0);
    applyStimulus(0, 639, 1'b0);

    pulse_load(31, 0, 1'b0);
    wait_ready();
    applyStimulus(285, 295, 1'b1);
    pulse_load(31, 63, 1'b0);
    wait_ready();
    applyStimulus(285, 295, 1'b1);
    pulse_load(31, 5, 1'b1);
    wait_ready();
    applyStimulus(285, 295, 1'b1);

    @(negedge clk);
    reset = 1'b1;
    load  = 1'b1;
    size  = 11'd31;
    @(posedge clk);
    #1;
    reset = 1'b0;
    load  = 1'b0;
    checkOutput("loadreset_busy",  int'(busy),  0);
    checkOutput("loadreset_ready", int'(ready), 0);
    applyStimulus(300, 340, 1'b0);

    for (int r = 0; r < 8; r++) begin
      sz = (r % 2 == 0) ? int'($urandom_range(400, 0)) : int'($urandom_range(2047, 0));
      tu = int'($urandom_range(63, 0));
      sd = 1'($urandom_range(1, 0));
      pulse_load(sz, tu, sd);
      wait_ready();
      for (int s = 0; s < 2; s++) begin
        lo = int'($urandom_range(m_start, 0));
        hi = int'($urandom_range(639, lo));
        applyStimulus(lo, hi, 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wall_slice_render.md
WALL_SLICE_RENDER -- requirements
Module: wall_slice_render

Interface
REQ-001 SHALL have parameter H_VIEW, default 640, meaning visible pixels per trace line; HALF = H_VIEW/2.
REQ-002 SHALL have parameter SIZE_W, default 11, meaning the width of the size input.
REQ-003 SHALL have parameter TEX_BITS, default 6, meaning log2 of the texture edge; TEX = 2^TEX_BITS.
REQ-004 SHALL have parameter FRAC, default 10, meaning the fractional bits of the texture step.
REQ-005 SHALL have one clock and a reset that is synchronous and active-high.
REQ-006 SHALL have these ports:
- clk  in  1  clock.
- reset  in  1  sync active-high reset.
- load  in  1  capture side/size/texu and start setup.
- side  in  1  wall side.
- size  in  SIZE_W  half-height, mirrored about HALF.
- texu  in  TEX_BITS  texture u coordinate.
- hpos  in  10  trace position; +1 per clk while active.
- busy  out  1  setup in progress.
- ready  out  1  row parameters valid.
- hit  out  1  registered: previous hpos inside span.
- texv  out  TEX_BITS  registered texture v coordinate.
- rgb  out  6  registered colour, BBGGRR.

Function
REQ-007 SHALL implement the FSM states IDLE, DIV, MUL and READY; busy=(DIV|MUL) and ready=READY.
REQ-008 On load in any state, SHALL latch side/size/texu and enter DIV on the next edge; a load while busy SHALL abort and restart with the new values.
REQ-009 SHALL use L = 2*size+1, in SIZE_W+1 bits.
REQ-010 DIV SHALL compute step = floor((TEX<<FRAC)/L), TEX_BITS+FRAC+1 bits wide, using a restoring divider at one quotient bit per cycle: exactly TEX_BITS+FRAC+1 cycles (17 at defaults).
REQ-011 SHALL use skip = size-HALF if size>HALF, else 0.
REQ-012 SHALL define start = 0 if skip>0, else HALF-size.
REQ-013 SHALL define end = min(HALF+size, H_VIEW-1).
REQ-014 MUL SHALL compute acc0 = skip*step by shift-add at one multiplier bit per cycle: exactly SIZE_W cycles; it SHALL then enter READY.
REQ-015 If load is sampled at edge k, ready SHALL be 1 from edge k+1+(TEX_BITS+FRAC+1)+SIZE_W (k+29 at defaults).
REQ-016 On each READY cycle with start<=hpos<=end, the next edge SHALL give hit=1; otherwise it SHALL give hit=0. In IDLE/DIV/MUL, hit SHALL be 0.
REQ-017 Accumulator, READY with hpos==start: texv<=sat(acc0>>FRAC) and acc<=acc0+step.
REQ-018 Accumulator, READY with hpos inside the span but not at start: texv<=sat(acc>>FRAC) and acc<=acc+step.
REQ-019 Accumulator, READY with hpos outside the span: acc SHALL be held, and texv<=0.
REQ-020 sat() SHALL clamp to TEX-1, and acc SHALL saturate rather than wrap.
REQ-021 A repeated sweep of hpos through the span SHALL reproduce identical texv, because it restarts from acc0.
REQ-022 rgb SHALL be registered alongside hit, and SHALL be 0 when not hit.
REQ-023 When hit, rgb SHALL follow this priority: latched texu==0 -> 11_10_00; texu==TEX-1 -> 01_00_00; side=1 -> 11_00_00; else 10_00_00.
REQ-024 The hit/texv/rgb latency relative to hpos SHALL be exactly 1 cycle.

Reset
REQ-025 Reset SHALL force IDLE and acc=acc0=step=0, with busy=ready=hit=0 and texv=rgb=0, at the next edge.
REQ-026 Reset SHALL take priority over a simultaneous load.
REQ-027 Reset mid-DIV/MUL SHALL discard the setup, and nothing SHALL become ready until a new load.

Verification
REQ-028 SHALL verify: load size=0, texu=5, side=0, then hpos sweep 318..322 in READY -> hit=1 only on the cycle after hpos=320, texv=0, rgb=10_00_00; busy for 28 cycles and ready at k+29.
REQ-029 SHALL verify: size=31 (step=1040), hpos 289..351 -> hit for 63 cycles; texv non-decreasing from 0 to 62; hit=0 at 288 and 352.
REQ-030 SHALL verify: size=320 (skip=0, step=102), hpos 0..639 -> hit all 640 cycles; texv=0 at hpos 0 and 63 at hpos 639.
REQ-031 SHALL verify: size=2047 (skip=1727, step=16, acc0=27632), hpos 0..639 -> texv=26 at hpos 0 and 36 at hpos 639; a second identical sweep -> identical texv.
REQ-032 SHALL verify: load size=10, then load size=31 eight cycles later -> the final step equals 1040 and ready comes 29 cycles after the second load; reset asserted during MUL -> IDLE and hit stays 0 through a full hpos sweep.
REQ-033 SHALL verify: texu=0 -> rgb 11_10_00; texu=63 -> 01_00_00; side=1 with texu=5 -> 11_00_00; and load coincident with reset -> IDLE.
